led_show_ctrl: RTL and testbench

//   Pattern engine driving the two 8-bit LED rows of the board top level. Consumes one slow divided

---
 rtl/led_show_ctrl_pkg.sv | 32 +++
 rtl/led_show_ctrl_if.sv | 27 ++
 rtl/led_show_ctrl_edge_sync.sv | 31 +++
 rtl/led_show_ctrl.sv | 112 +++++++++++
 tb/tb_led_show_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/led_show_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_show_pkg : shared constants, mode encoding and helpers for LED engine  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package led_show_pkg;

  localparam int LED_W = 8;

  typedef enum logic [1:0] {
    MODE_COUNT = 2'd0,
    MODE_WALK  = 2'd1,
    MODE_PN    = 2'd2,
    MODE_HOLD  = 2'd3
  } mode_e;

  // Taps p[7]^p[5]^p[4]^p[3] realise x^8+x^6+x^5+x^4+1 with a left shift
  localparam logic [LED_W-1:0] LFSR_TAPS  = 8'hB8;
  localparam logic [LED_W-1:0] SEED_COUNT = 8'h00;
  localparam logic [LED_W-1:0] SEED_WALK  = 8'h01;

  function automatic logic [LED_W-1:0] bit_rev(input logic [LED_W-1:0] v);
    logic [LED_W-1:0] r;
    r = '0;
    for (int i = 0; i < LED_W; i++) begin
      r[i] = v[LED_W-1-i];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_show_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_show_ctrl_if : rate/mode/pause controls and LED row outputs            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface led_show_ctrl_if;
  import led_show_pkg::*;

  logic             rate_clk;
  logic [1:0]       mode;
  logic             pause;
  logic [LED_W-1:0] led_1;
  logic [LED_W-1:0] led_2;
  logic             step;

  modport master (
    output rate_clk, mode, pause,
    input  led_1, led_2, step
  );

  modport slave (
    input  rate_clk, mode, pause,
    output led_1, led_2, step
  );

endinterface
`default_nettype wire

// File: rtl/led_show_ctrl_edge_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | edge_sync : multi-flop synchroniser with one-cycle rising-edge pulse       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  wire logic sys_clk,
  input  wire logic reset,
  input  wire logic i_async,
  output logic      o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_edge;

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
      r_edge <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_edge <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_edge;

endmodule
`default_nettype wire

// File: rtl/led_show_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_show_ctrl : four-mode LED pattern engine stepped by a resynced rate    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module led_show_ctrl
  import led_show_pkg::*;
#(
  parameter int               SYNC_STAGES = 2,
  parameter logic [LED_W-1:0] PN_SEED     = 8'h01
) (
  input  wire logic       sys_clk,
  input  wire logic       reset,
  led_show_ctrl_if.slave  bus
);

  logic             w_tick;
  logic             w_accept;
  mode_e            w_req_mode;
  mode_e            r_cur_mode;
  mode_e            w_mode_nxt;
  logic [LED_W-1:0] r_pattern;
  logic [LED_W-1:0] w_pat_nxt;
  logic [LED_W-1:0] w_pn_nxt;
  logic [LED_W-1:0] r_led_1;
  logic [LED_W-1:0] r_led_2;
  logic [LED_W-1:0] w_led_1_nxt;
  logic [LED_W-1:0] w_led_2_nxt;
  logic             r_step;

  edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rate_sync (
    .sys_clk (sys_clk),
    .reset   (reset),
    .i_async (bus.rate_clk),
    .o_rise  (w_tick)
  );

  assign w_accept   = w_tick & ~bus.pause;
  assign w_req_mode = mode_e'(bus.mode);

  // An all-zero register would lock the LFSR, so it is reseeded instead
  assign w_pn_nxt = (r_pattern == '0) ? PN_SEED
                                      : {r_pattern[LED_W-2:0], ^(r_pattern & LFSR_TAPS)};

  always_comb begin
    w_mode_nxt = r_cur_mode;
    w_pat_nxt  = r_pattern;
    if (w_accept) begin
      if (w_req_mode != r_cur_mode) begin
        w_mode_nxt = w_req_mode;
        case (w_req_mode)
          MODE_COUNT: w_pat_nxt = SEED_COUNT;
          MODE_WALK:  w_pat_nxt = SEED_WALK;
          MODE_PN:    w_pat_nxt = PN_SEED;
          default:    w_pat_nxt = r_pattern;
        endcase
      end else begin
        case (r_cur_mode)
          MODE_COUNT: w_pat_nxt = r_pattern + 8'd1;
          MODE_WALK:  w_pat_nxt = {r_pattern[LED_W-2:0], r_pattern[LED_W-1]};
          MODE_PN:    w_pat_nxt = w_pn_nxt;
          default:    w_pat_nxt = r_pattern;
        endcase
      end
    end
  end

  always_comb begin
    w_led_1_nxt = r_led_1;
    w_led_2_nxt = r_led_2;
    if (w_accept) begin
      case (w_mode_nxt)
        MODE_COUNT, MODE_WALK: begin
          w_led_1_nxt = w_pat_nxt;
          w_led_2_nxt = bit_rev(w_pat_nxt);
        end
        MODE_PN: begin
          w_led_1_nxt = w_pat_nxt;
          w_led_2_nxt = ~w_pat_nxt;
        end
        default: begin
          w_led_1_nxt = r_led_1;
          w_led_2_nxt = r_led_2;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      r_cur_mode <= MODE_COUNT;
      r_pattern  <= '0;
      r_led_1    <= '0;
      r_led_2    <= '0;
      r_step     <= 1'b0;
    end else begin
      r_cur_mode <= w_mode_nxt;
      r_pattern  <= w_pat_nxt;
      r_led_1    <= w_led_1_nxt;
      r_led_2    <= w_led_2_nxt;
      r_step     <= w_accept;
    end
  end

  assign bus.led_1 = r_led_1;
  assign bus.led_2 = r_led_2;
  assign bus.step  = r_step;

endmodule
`default_nettype wire

// File: tb/tb_led_show_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_led_show_ctrl : directed stimulus against a pattern-level reference     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_led_show_ctrl;

  localparam int         SYNC_STAGES = 2;
  localparam logic [7:0] PN_SEED     = 8'h01;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  led_show_ctrl_if bus ();

  led_show_ctrl #(
    .SYNC_STAGES (SYNC_STAGES),
    .PN_SEED     (PN_SEED)
  ) dut (
    .sys_clk (clk),
    .reset   (rst_n),
    .bus     (bus)
  );

  int   n_cmp  = 0;
  int   n_bad  = 0;
  bit   chk_en = 1'b0;

  int         m_mode;
  logic [7:0] m_pat;
  logic [7:0] m_l1;
  logic [7:0] m_l2;
  logic       exp_step;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode   = 0;
    m_pat    = 8'h00;
    m_l1     = 8'h00;
    m_l2     = 8'h00;
    exp_step = 1'b0;
  endtask

  // Applies one rate edge to the reference as the pattern rules describe it
  task automatic model_accept(input logic p, input logic [1:0] md);
    if (p) return;
    exp_step = 1'b1;
    if (int'(md) != m_mode) begin
      m_mode = int'(md);
      if (m_mode == 0)      m_pat = 8'h00;
      else if (m_mode == 1) m_pat = 8'h01;
      else if (m_mode == 2) m_pat = PN_SEED;
    end else if (m_mode == 0) begin
      m_pat = 8'((int'(m_pat) + 1) % 256);
    end else if (m_mode == 1) begin
      m_pat = (m_pat == 8'h80) ? 8'h01 : 8'(int'(m_pat) * 2);
    end else if (m_mode == 2) begin
      if (m_pat == 8'h00) m_pat = PN_SEED;
      else m_pat = {m_pat[6:0], m_pat[7] ^ m_pat[5] ^ m_pat[4] ^ m_pat[3]};
    end
    if (m_mode == 0 || m_mode == 1) begin
      m_l1 = m_pat;
      m_l2 = rev8(m_pat);
    end else if (m_mode == 2) begin
      m_l1 = m_pat;
      m_l2 = ~m_pat;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check8("led_1", bus.led_1, m_l1);
      check8("led_2", bus.led_2, m_l2);
      check1("step", bus.step, exp_step);
    end
  end

  task automatic rate_edge();
    @(negedge clk);
    #2 bus.rate_clk = 1'b1;
    repeat (SYNC_STAGES + 1) @(posedge clk);
    model_accept(bus.pause, bus.mode);
    @(posedge clk);
    exp_step = 1'b0;
    @(negedge clk);
    bus.rate_clk = 1'b0;
    repeat (SYNC_STAGES + 2) @(posedge clk);
  endtask

  task automatic lit(input string name, input logic [7:0] e1, input logic [7:0] e2);
    #1;
    check8({name, "_l1"}, bus.led_1, e1);
    check8({name, "_l2"}, bus.led_2, e2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int ret_at;
    bus.rate_clk = 1'b0;
    bus.mode     = 2'd0;
    bus.pause    = 1'b0;
    model_reset();
    #1 chk_en = 1'b1;

    // T1: reset held while rate_clk toggles
    repeat (3) begin
      repeat (2) @(negedge clk);
      bus.rate_clk = 1'b1;
      repeat (2) @(negedge clk);
      bus.rate_clk = 1'b0;
    end
    lit("t1_reset", 8'h00, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // T2: COUNT through wrap
    rate_edge();
    lit("t2_first", 8'h01, 8'h80);
    for (int i = 2; i <= 258; i++) begin
      rate_edge();
      if (i == 255) lit("t2_ff", 8'hFF, 8'hFF);
      if (i == 256) lit("t2_wrap", 8'h00, 8'h00);
    end
    lit("t2_end", 8'h02, 8'h40);

    // T3: WALK entered from COUNT=05
    repeat (3) rate_edge();
    lit("t3_pre", 8'h05, 8'hA0);
    bus.mode = 2'd1;
    rate_edge();
    lit("t3_load", 8'h01, 8'h80);
    rate_edge();
    lit("t3_w1", 8'h02, 8'h40);
    repeat (6) rate_edge();
    lit("t3_top", 8'h80, 8'h01);
    rate_edge();
    lit("t3_wrap", 8'h01, 8'h80);

    // T4: PN sequence and period
    bus.mode = 2'd2;
    rate_edge();
    lit("t4_load", 8'h01, 8'hFE);
    ret_at = 0;
    for (int i = 1; i <= 255; i++) begin
      rate_edge();
      if (i == 1) lit("t4_s1", 8'h02, 8'hFD);
      if (i == 3) lit("t4_s3", 8'h08, 8'hF7);
      if (i == 4) lit("t4_s4", 8'h11, 8'hEE);
      #1;
      if (bus.led_1 == 8'h01 && ret_at == 0) ret_at = i;
    end
    check_int("t4_period", ret_at, 255);

    // T5: pause drops ticks, HOLD pulses step without change, mode glitch ignored
    bus.pause = 1'b1;
    repeat (3) rate_edge();
    lit("t5_pause", 8'h01, 8'hFE);
    bus.pause = 1'b0;
    bus.mode  = 2'd3;
    @(negedge clk);
    #2 bus.rate_clk = 1'b1;
    repeat (SYNC_STAGES + 1) @(posedge clk);
    model_accept(bus.pause, bus.mode);
    #1 check1("t5_hold_step", bus.step, 1'b1);
    @(posedge clk) exp_step = 1'b0;
    @(negedge clk) bus.rate_clk = 1'b0;
    repeat (SYNC_STAGES + 2) @(posedge clk);
    lit("t5_hold", 8'h01, 8'hFE);
    bus.mode = 2'd0;
    repeat (2) @(posedge clk);
    bus.mode = 2'd3;
    repeat (2) @(posedge clk);
    rate_edge();
    lit("t5_glitch", 8'h01, 8'hFE);
    bus.mode = 2'd0;
    rate_edge();
    lit("t5_count", 8'h00, 8'h00);
    rate_edge();
    lit("t5_count1", 8'h01, 8'h80);

    // T6: tick latency, then reset between tick and update
    @(negedge clk);
    #2 bus.rate_clk = 1'b1;
    @(posedge clk);
    #1 check1("t6_lat1", bus.step, 1'b0);
    @(posedge clk);
    #1 check1("t6_lat2", bus.step, 1'b0);
    @(posedge clk);
    model_accept(bus.pause, bus.mode);
    #1 check1("t6_lat3", bus.step, 1'b1);
    @(posedge clk) exp_step = 1'b0;
    #1 check1("t6_lat4", bus.step, 1'b0);
    @(negedge clk) bus.rate_clk = 1'b0;
    repeat (SYNC_STAGES + 2) @(posedge clk);
    lit("t6_adv", 8'h02, 8'h40);

    @(negedge clk);
    #2 bus.rate_clk = 1'b1;
    repeat (SYNC_STAGES) @(posedge clk);
    #2;
    rst_n        = 1'b0;
    bus.rate_clk = 1'b0;
    model_reset();
    lit("t6_rst", 8'h00, 8'h00);
    @(posedge clk);
    #1 check1("t6_no_late_step", bus.step, 1'b0);
    repeat (2) @(posedge clk);
    bus.mode = 2'd1;
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    rate_edge();
    lit("t6_live_mode", 8'h01, 8'h80);

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
